// File: rtl/control_pkg.sv
// Shared encodings and the control bundle carried down the control pipeline.
package control_pkg;

    typedef enum logic [1:0] {
        OPDATA   = 2'b00,
        OPMEMORY = 2'b01,
        OPBRANCH = 2'b10
    } opcode_t;

    localparam logic [3:0] FNOP     = 4'h0;
    localparam logic [3:0] FSUB     = 4'h2;
    localparam logic [3:0] FADD     = 4'h4;
    localparam logic [3:0] FMULT    = 4'h9;
    localparam logic [3:0] FAVERAGE = 4'hA;

    typedef enum logic [3:0] {
        NOP  = 4'd0,
        ADD  = 4'd1,
        SUB  = 4'd2,
        MULT = 4'd3,
        AV   = 4'd4
    } alu_op_t;

    typedef enum logic [3:0] {
        EQ = 4'd0,
        NE = 4'd1,
        CS = 4'd2,
        CC = 4'd3,
        MI = 4'd4,
        PL = 4'd5,
        GE = 4'd10,
        LT = 4'd11,
        AL = 4'd14
    } cond_t;

    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       plusone;
        logic       branch;
        logic [1:0] flagw;
        alu_op_t    alu;
        logic [3:0] cond;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BUBBLE = '0;

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM-style condition code against the NZCV flags (N=3, Z=2, C=1, V=0).
module cond_check
    import control_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    always_comb begin
        pass = 1'b0;
        case (cond)
            EQ:      pass = nzcv[2];
            NE:      pass = ~nzcv[2];
            CS:      pass = nzcv[1];
            CC:      pass = ~nzcv[1];
            MI:      pass = nzcv[3];
            PL:      pass = ~nzcv[3];
            GE:      pass = (nzcv[3] == nzcv[0]);
            LT:      pass = (nzcv[3] != nzcv[0]);
            AL:      pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_pipeline.sv
// Pipelined control unit: decodes in D, carries control through E/M/W with
// conditional execution, an NZCV register and a busy counter for MULT/AV.
module control_pipeline
    import control_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int MUL_LAT   = 3,
    parameter int AV_LAT    = 4,
    parameter int COND_EN   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           opcode_d,
    input  logic [5:0]           funct_d,
    input  logic [3:0]           cond_d,
    input  logic [3:0]           alu_flags_e,
    input  logic                 stall_d,
    input  logic                 flush_e,
    output logic [1:0]           regsrc_d,
    output logic [1:0]           immsrc_d,
    output logic                 alusrc_e,
    output logic [ALUCTRL_W-1:0] aluctrl_e,
    output logic                 plusone_e,
    output logic                 branch_taken_e,
    output logic                 memwrite_m,
    output logic                 regwrite_m,
    output logic                 regwrite_w,
    output logic                 memtoreg_w,
    output logic [3:0]           flags,
    output logic                 busy
);

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] AV_CNT  = 4'(AV_LAT - 1);

    ctrl_bundle_t dec, e_q;
    logic [3:0]   cmd, load_cnt, cnt_q;
    logic         memtoreg_m, pass;

    assign cmd = funct_d[4:1];

    always_comb begin
        // NOTE: every field gets a default before the case so no latch is inferred.
        dec = BUBBLE;
        case (opcode_d)
            OPDATA: begin
                dec.alusrc = funct_d[5];
                case (cmd)
                    FADD:     dec.alu = ADD;
                    FSUB:     dec.alu = SUB;
                    FMULT:    dec.alu = MULT;
                    FAVERAGE: dec.alu = AV;
                    default:  dec.alu = NOP;
                endcase
                // S=1 is the compare form; FNOP and unknown cmds decode to NOP
                dec.regwrite = ~funct_d[0] & (dec.alu != NOP);
                dec.flagw    = {funct_d[0], funct_d[0] & (dec.alu == ADD || dec.alu == SUB)};
            end
            OPMEMORY: begin
                dec.alu      = funct_d[3] ? SUB : ADD;
                dec.alusrc   = 1'b1;
                dec.memwrite = ~funct_d[0];
                dec.memtoreg = funct_d[0];
                dec.regwrite = funct_d[0];
                dec.plusone  = funct_d[4];
            end
            OPBRANCH: begin
                dec.alu    = ADD;
                dec.alusrc = 1'b1;
                dec.branch = 1'b1;
            end
            default: dec = BUBBLE;
        endcase
        dec.cond = (COND_EN != 0) ? cond_d : AL;
    end

    assign immsrc_d = {opcode_d == OPBRANCH, opcode_d == OPMEMORY};
    assign regsrc_d = {(opcode_d == OPMEMORY) & ~funct_d[0], opcode_d == OPBRANCH};

    always_comb begin
        load_cnt = '0;
        if (dec.alu == MULT)    load_cnt = MUL_CNT;
        else if (dec.alu == AV) load_cnt = AV_CNT;
    end

    assign busy = (cnt_q != '0);

    cond_check u_cond_check (
        .cond (e_q.cond),
        .nzcv (flags),
        .pass (pass)
    );

    // NOTE: reset is sampled on the clock edge only; state updates use <= so all stages move together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q   <= BUBBLE;
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q - 4'd1;
        end else if (flush_e || stall_d) begin
            e_q   <= BUBBLE;
            cnt_q <= '0;
        end else begin
            e_q   <= dec;
            cnt_q <= load_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            regwrite_m <= 1'b0;
            memwrite_m <= 1'b0;
            memtoreg_m <= 1'b0;
            regwrite_w <= 1'b0;
            memtoreg_w <= 1'b0;
        end else begin
            regwrite_w <= regwrite_m;
            memtoreg_w <= memtoreg_m;
            if (busy) begin
                regwrite_m <= 1'b0;
                memwrite_m <= 1'b0;
                memtoreg_m <= 1'b0;
            end else begin
                regwrite_m <= e_q.regwrite & pass;
                memwrite_m <= e_q.memwrite & pass;
                memtoreg_m <= e_q.memtoreg;
            end
        end
    end

    // Flags commit only when the instruction actually leaves E and its condition held
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags <= '0;
        end else if (!busy && pass) begin
            if (e_q.flagw[1]) flags[3:2] <= alu_flags_e[3:2];
            if (e_q.flagw[0]) flags[1:0] <= alu_flags_e[1:0];
        end
    end

    assign alusrc_e       = e_q.alusrc;
    assign aluctrl_e      = ALUCTRL_W'(e_q.alu);
    assign plusone_e      = e_q.plusone;
    assign branch_taken_e = e_q.branch & pass & ~busy;

endmodule

// File: tb/tb_control_pipeline.sv
// Self-checking bench for control_pipeline: directed scenarios plus randomized
// traffic compared against an occupancy-based behavioural model.
module tb_control_pipeline;

    localparam int AW      = 4;
    localparam int MUL_LAT = 3;
    localparam int AV_LAT  = 4;
    localparam int COND_EN = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    opcode_d = 2'b11;
    logic [5:0]    funct_d = 6'h00;
    logic [3:0]    cond_d = 4'd14;
    logic [3:0]    alu_flags_e = 4'h0;
    logic          stall_d = 1'b0;
    logic          flush_e = 1'b0;
    logic [1:0]    regsrc_d, immsrc_d;
    logic          alusrc_e, plusone_e, branch_taken_e;
    logic [AW-1:0] aluctrl_e;
    logic          memwrite_m, regwrite_m, regwrite_w, memtoreg_w, busy;
    logic [3:0]    flags;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_pipeline #(
        .ALUCTRL_W (AW),
        .MUL_LAT   (MUL_LAT),
        .AV_LAT    (AV_LAT),
        .COND_EN   (COND_EN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .opcode_d       (opcode_d),
        .funct_d        (funct_d),
        .cond_d         (cond_d),
        .alu_flags_e    (alu_flags_e),
        .stall_d        (stall_d),
        .flush_e        (flush_e),
        .regsrc_d       (regsrc_d),
        .immsrc_d       (immsrc_d),
        .alusrc_e       (alusrc_e),
        .aluctrl_e      (aluctrl_e),
        .plusone_e      (plusone_e),
        .branch_taken_e (branch_taken_e),
        .memwrite_m     (memwrite_m),
        .regwrite_m     (regwrite_m),
        .regwrite_w     (regwrite_w),
        .memtoreg_w     (memtoreg_w),
        .flags          (flags),
        .busy           (busy)
    );

    // Reference model: instruction in E plus the number of cycles it still occupies E
    typedef struct {
        bit       rw, mw, mtr, als, p1, br;
        bit [1:0] fw;
        int       alu;
        bit [3:0] cond;
    } m_ctl_t;

    m_ctl_t   me;
    int       mleft = 1;
    bit       m_rw, m_mw, m_mtr, w_rw, w_mtr;
    bit [3:0] mflags;

    function automatic m_ctl_t bubble();
        m_ctl_t c;
        c = '{default: 0};
        return c;
    endfunction

    function automatic m_ctl_t dec(input logic [1:0] op, input logic [5:0] f);
        m_ctl_t c;
        int cmd;
        c   = bubble();
        cmd = int'(f[4:1]);
        case (op)
            2'd0: begin
                c.als = f[5];
                case (cmd)
                    4:       c.alu = 1;
                    2:       c.alu = 2;
                    9:       c.alu = 3;
                    10:      c.alu = 4;
                    default: c.alu = 0;
                endcase
                c.rw = (c.alu != 0) && !f[0];
                c.fw = {f[0], f[0] && (c.alu == 1 || c.alu == 2)};
            end
            2'd1: begin
                c.alu = f[3] ? 2 : 1;
                c.als = 1; c.mw = !f[0]; c.mtr = f[0]; c.rw = f[0]; c.p1 = f[4];
            end
            2'd2: begin
                c.alu = 1; c.als = 1; c.br = 1;
            end
            default: c = bubble();
        endcase
        return c;
    endfunction

    function automatic bit tb_pass(input logic [3:0] c, input logic [3:0] f);
        if (COND_EN == 0) return 1'b1;
        case (c)
            4'd0:    return f[2];
            4'd1:    return !f[2];
            4'd2:    return f[1];
            4'd3:    return !f[1];
            4'd4:    return f[3];
            4'd5:    return !f[3];
            4'd10:   return f[3] == f[0];
            4'd11:   return f[3] != f[0];
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_edge();
        bit p;
        if (!reset) begin
            me = bubble(); mleft = 1; mflags = 4'h0;
            m_rw = 0; m_mw = 0; m_mtr = 0; w_rw = 0; w_mtr = 0;
            return;
        end
        w_rw  = m_rw;
        w_mtr = m_mtr;
        if (mleft > 1) begin
            m_rw = 0; m_mw = 0; m_mtr = 0;
            mleft--;
            return;
        end
        p     = tb_pass(me.cond, mflags);
        m_rw  = me.rw & p;
        m_mw  = me.mw & p;
        m_mtr = me.mtr;
        if (p && me.fw[1]) mflags[3:2] = alu_flags_e[3:2];
        if (p && me.fw[0]) mflags[1:0] = alu_flags_e[1:0];
        if (flush_e || stall_d) begin
            me = bubble(); mleft = 1;
        end else begin
            me      = dec(opcode_d, funct_d);
            me.cond = cond_d;
            mleft   = (me.alu == 3) ? MUL_LAT : (me.alu == 4) ? AV_LAT : 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [3:0] c);
        opcode_d = op; funct_d = f; cond_d = c;
    endtask

    task automatic test_reset();
        logic [20:0] act;
        reset = 1'b0;
        drive(2'b11, 6'h00, 4'd14);
        tick(); tick();
        act = {regsrc_d, immsrc_d, alusrc_e, aluctrl_e, plusone_e, branch_taken_e,
               memwrite_m, regwrite_m, regwrite_w, memtoreg_w, flags, busy, 1'b0};
        n_vec++; if (act !== '0) begin n_err++; $display("FAIL reset_held: got %h want 0", act); end
        reset = 1'b1;
        tick();
        act = {regsrc_d, immsrc_d, alusrc_e, aluctrl_e, plusone_e, branch_taken_e,
               memwrite_m, regwrite_m, regwrite_w, memtoreg_w, flags, busy, 1'b0};
        n_vec++; if (act !== '0) begin n_err++; $display("FAIL reset_release: got %h want 0", act); end
    endtask

    task automatic test_flags_branch();
        drive(2'b00, 6'h09, 4'd14);
        tick();
        n_vec++; if (aluctrl_e !== 4'd1) begin n_err++; $display("FAIL add_in_e: got %0d want 1", aluctrl_e); end
        n_vec++; if (flags !== 4'b0000) begin n_err++; $display("FAIL flags_before_add: got %b want 0000", flags); end
        alu_flags_e = 4'b0100;
        drive(2'b10, 6'h00, 4'd0);
        #1;
        n_vec++; if ({immsrc_d, regsrc_d} !== 4'b1001) begin n_err++; $display("FAIL branch_decode: got %b want 1001", {immsrc_d, regsrc_d}); end
        tick();
        alu_flags_e = 4'h0;
        n_vec++; if (flags !== 4'b0100) begin n_err++; $display("FAIL flags_after_add: got %b want 0100", flags); end
        n_vec++; if (branch_taken_e !== 1'b1) begin n_err++; $display("FAIL branch_eq_taken: got %b want 1", branch_taken_e); end
        drive(2'b10, 6'h00, 4'd1);
        tick();
        n_vec++; if (branch_taken_e !== 1'b0) begin n_err++; $display("FAIL branch_ne_not_taken: got %b want 0", branch_taken_e); end
        drive(2'b11, 6'h00, 4'd14);
        tick();
    endtask

    task automatic test_mult();
        drive(2'b00, 6'h12, 4'd14);
        tick();
        n_vec++; if ({busy, aluctrl_e} !== 5'b1_0011) begin n_err++; $display("FAIL mult_c0: got %b want 10011", {busy, aluctrl_e}); end
        drive(2'b00, 6'h08, 4'd14);
        tick();
        n_vec++; if ({busy, aluctrl_e, regwrite_m} !== 6'b1_0011_0) begin n_err++; $display("FAIL mult_c1: got %b want 100110", {busy, aluctrl_e, regwrite_m}); end
        tick();
        n_vec++; if ({busy, aluctrl_e, regwrite_m} !== 6'b0_0011_0) begin n_err++; $display("FAIL mult_c2: got %b want 000110", {busy, aluctrl_e, regwrite_m}); end
        tick();
        n_vec++; if ({aluctrl_e, regwrite_m} !== 5'b0001_1) begin n_err++; $display("FAIL mult_to_m: got %b want 00011", {aluctrl_e, regwrite_m}); end
        tick();
        n_vec++; if ({regwrite_m, regwrite_w} !== 2'b11) begin n_err++; $display("FAIL add_after_mult: got %b want 11", {regwrite_m, regwrite_w}); end
        drive(2'b11, 6'h00, 4'd14);
        tick();
    endtask

    task automatic test_cond_store();
        drive(2'b00, 6'h09, 4'd1);
        tick();
        alu_flags_e = 4'hF;
        drive(2'b01, 6'h00, 4'd1);
        #1;
        n_vec++; if ({regsrc_d, immsrc_d} !== 4'b1001) begin n_err++; $display("FAIL store_decode: got %b want 1001", {regsrc_d, immsrc_d}); end
        tick();
        alu_flags_e = 4'h0;
        n_vec++; if (flags !== 4'b0100) begin n_err++; $display("FAIL flags_cond_fail: got %b want 0100", flags); end
        drive(2'b01, 6'h00, 4'd0);
        tick();
        n_vec++; if ({memwrite_m, regwrite_m} !== 2'b00) begin n_err++; $display("FAIL store_ne_squashed: got %b want 00", {memwrite_m, regwrite_m}); end
        tick();
        n_vec++; if (memwrite_m !== 1'b1) begin n_err++; $display("FAIL store_eq_writes: got %b want 1", memwrite_m); end
        drive(2'b11, 6'h00, 4'd14);
        tick(); tick();
    endtask

    task automatic test_flush_stall();
        drive(2'b00, 6'h12, 4'd14);
        tick();
        flush_e = 1'b1; stall_d = 1'b1;
        drive(2'b00, 6'h08, 4'd14);
        tick();
        n_vec++; if ({busy, aluctrl_e} !== 5'b1_0011) begin n_err++; $display("FAIL flush_ignored_c1: got %b want 10011", {busy, aluctrl_e}); end
        tick();
        n_vec++; if ({busy, aluctrl_e} !== 5'b0_0011) begin n_err++; $display("FAIL flush_ignored_c2: got %b want 00011", {busy, aluctrl_e}); end
        stall_d = 1'b0;
        tick();
        n_vec++; if ({aluctrl_e, regwrite_m} !== 5'b0000_1) begin n_err++; $display("FAIL flush_idle_bubble: got %b want 00001", {aluctrl_e, regwrite_m}); end
        flush_e = 1'b0; stall_d = 1'b1;
        tick();
        n_vec++; if (aluctrl_e !== 4'd0) begin n_err++; $display("FAIL stall_idle_bubble: got %0d want 0", aluctrl_e); end
        stall_d = 1'b0;
        tick();
        n_vec++; if (aluctrl_e !== 4'd1) begin n_err++; $display("FAIL resume_after_stall: got %0d want 1", aluctrl_e); end
        drive(2'b11, 6'h00, 4'd14);
        tick();
    endtask

    task automatic test_reset_busy();
        drive(2'b00, 6'h14, 4'd14);
        tick();
        n_vec++; if ({busy, aluctrl_e} !== 5'b1_0100) begin n_err++; $display("FAIL av_in_e: got %b want 10100", {busy, aluctrl_e}); end
        tick();
        reset = 1'b0;
        drive(2'b11, 6'h00, 4'd14);
        tick();
        n_vec++; if ({busy, aluctrl_e, regwrite_m, regwrite_w, memtoreg_w, flags} !== 12'h000) begin
            n_err++; $display("FAIL reset_mid_av: got %b want 0", {busy, aluctrl_e, regwrite_m, regwrite_w, memtoreg_w, flags});
        end
        reset = 1'b1;
        tick(); tick();
        n_vec++; if ({regwrite_m, regwrite_w} !== 2'b00) begin n_err++; $display("FAIL no_partial_av: got %b want 00", {regwrite_m, regwrite_w}); end
    endtask

    task automatic test_random(input int cycles);
        logic [19:0] act, exp;
        m_ctl_t d;
        bit br;
        for (int i = 0; i < cycles; i++) begin
            reset       = ($urandom_range(0, 79) != 0);
            stall_d     = ($urandom_range(0, 7) == 0);
            flush_e     = ($urandom_range(0, 7) == 0);
            alu_flags_e = 4'($urandom);
            funct_d     = 6'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 4))
                    0: funct_d[4:1] = 4'h4;
                    1: funct_d[4:1] = 4'h2;
                    2: funct_d[4:1] = 4'h9;
                    3: funct_d[4:1] = 4'hA;
                    default: funct_d[4:1] = 4'h0;
                endcase
            end
            opcode_d = 2'($urandom);
            cond_d   = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom);
            #1;
            d   = dec(opcode_d, funct_d);
            br  = me.br && tb_pass(me.cond, mflags) && !(mleft > 1);
            exp = {opcode_d == 2'd1 && !funct_d[0], opcode_d == 2'd2, opcode_d == 2'd2, opcode_d == 2'd1,
                   me.als, me.alu[3:0], me.p1, br, m_mw, m_rw, w_rw, w_mtr, mflags, mleft > 1};
            act = {regsrc_d, immsrc_d, alusrc_e, aluctrl_e, plusone_e, branch_taken_e,
                   memwrite_m, regwrite_m, regwrite_w, memtoreg_w, flags, busy};
            n_vec++;
            if (act !== exp) begin
                n_err++;
                $display("FAIL random_cycle_%0d: got %b want %b (d.alu=%0d)", i, act, exp, d.alu);
            end
            tick();
        end
        reset = 1'b1; stall_d = 1'b0; flush_e = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        me = bubble();
        test_reset();
        test_flags_branch();
        test_mult();
        test_cond_store();
        test_flush_stall();
        test_reset_busy();
        test_random(600);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
